// File: rtl/fp16_normalize_pkg.sv
// Shared constants and FSM encoding for the FP16 post-add normaliser.
package fp16_normalize_pkg;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int EXP_BIAS = 15;

  localparam logic [EXP_W-1:0] EXP_MAX = 5'd31;
  localparam logic [EXP_W-1:0] EXP_ONE = 5'd1;
  localparam logic [EXP_W-1:0] EXP_DEC = 5'h1F;

  typedef enum logic [1:0] {
    FSM_IDLE  = 2'd0,
    FSM_EVAL  = 2'd1,
    FSM_SHIFT = 2'd2,
    FSM_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/cla_nbit.sv
// n-bit carry-lookahead adder: s = a + b + ci.
module cla_nbit #(
  parameter int n = 4
) (
  input  logic [n-1:0] a_i,
  input  logic [n-1:0] b_i,
  input  logic         ci_i,
  output logic [n-1:0] s_o,
  output logic         co_o
);

  logic [n-1:0] g;
  logic [n-1:0] p;
  logic [n:0]   c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Each carry is built from the generate/propagate prefix, not rippled.
  always_comb begin
    logic pp;
    c    = '0;
    pp   = 1'b1;
    c[0] = ci_i;
    for (int i = 1; i <= n; i++) begin
      pp = 1'b1;
      for (int j = i - 1; j >= 0; j--) begin
        c[i] = c[i] | (pp & g[j]);
        pp   = pp & p[j];
      end
      c[i] = c[i] | (pp & ci_i);
    end
  end

  assign s_o  = p ^ c[n-1:0];
  assign co_o = c[n];

endmodule

// File: rtl/fp16_normalize.sv
// Iterative FP16 post-add normaliser with valid/ready on both sides.
// Build option: FP16_NORM_SUBNORM_EN emits subnormals instead of flushing.
module fp16_normalize
  import fp16_normalize_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [MAN_W+1:0] in_mant,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_result,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_uf
);

  state_e           state_q;
  logic             sign_q;
  logic [EXP_W-1:0] exp_q;
  logic [MAN_W+1:0] mant_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [15:0]      result_q;
  logic             zero_q;
  logic             ovf_q;
  logic             uf_q;

  logic [EXP_W-1:0] add_b;
  logic [EXP_W-1:0] exp_sum;
  logic             add_co_unused;
  logic             do_shift;
  logic [EXP_W-1:0] exp_d;
  logic [MAN_W+1:0] mant_d;

  // One adder serves both the carry-out increment and the shift decrement.
  assign add_b = (state_q == FSM_EVAL) ? EXP_ONE : EXP_DEC;

  cla_nbit #(.n(EXP_W)) u_exp_add (
    .a_i  (exp_q),
    .b_i  (add_b),
    .ci_i (1'b0),
    .s_o  (exp_sum),
    .co_o (add_co_unused)
  );

  always_comb begin
    do_shift = 1'b0;
    exp_d    = exp_q;
    mant_d   = mant_q;
    if (state_q == FSM_SHIFT && !mant_q[MAN_W] && exp_q > EXP_ONE) begin
      do_shift = 1'b1;
      exp_d    = exp_sum;
      mant_d   = mant_q << 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FSM_IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      uf_q        <= 1'b0;
    end else begin
      unique case (state_q)
        FSM_IDLE: begin
          if (in_valid) begin
            sign_q     <= in_sign;
            exp_q      <= (in_exp == '0) ? EXP_ONE : in_exp;
            mant_q     <= in_mant;
            in_ready_q <= 1'b0;
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
            uf_q       <= 1'b0;
            state_q    <= FSM_EVAL;
          end
        end
        FSM_EVAL: begin
          if (mant_q == '0) begin
            result_q    <= {sign_q, 15'b0};
            zero_q      <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= FSM_DONE;
          end else if (mant_q[MAN_W+1]) begin
            mant_q <= mant_q >> 1;
            exp_q  <= exp_sum;
            if (exp_sum == EXP_MAX) begin
              result_q <= {sign_q, EXP_MAX, 10'h000};
              ovf_q    <= 1'b1;
            end else begin
              result_q <= {sign_q, exp_sum, mant_q[MAN_W:1]};
            end
            out_valid_q <= 1'b1;
            state_q     <= FSM_DONE;
          end else if (mant_q[MAN_W]) begin
            result_q    <= {sign_q, exp_q, mant_q[MAN_W-1:0]};
            out_valid_q <= 1'b1;
            state_q     <= FSM_DONE;
          end else begin
            state_q <= FSM_SHIFT;
          end
        end
        FSM_SHIFT: begin
          mant_q <= mant_d;
          exp_q  <= exp_d;
          if (mant_d[MAN_W]) begin
            result_q    <= {sign_q, exp_d, mant_d[MAN_W-1:0]};
            out_valid_q <= 1'b1;
            state_q     <= FSM_DONE;
          end else if (exp_d == EXP_ONE) begin
`ifdef FP16_NORM_SUBNORM_EN
            result_q <= {sign_q, 5'h00, mant_d[MAN_W-1:0]};
            uf_q     <= 1'b0;
`else
            result_q <= {sign_q, 15'b0};
            zero_q   <= 1'b1;
            uf_q     <= 1'b1;
`endif
            out_valid_q <= 1'b1;
            state_q     <= FSM_DONE;
          end
        end
        FSM_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= FSM_IDLE;
          end
        end
        default: state_q <= FSM_IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = result_q;
  assign out_zero   = zero_q;
  assign out_ovf    = ovf_q;
  assign out_uf     = uf_q;

endmodule

// File: tb/tb_fp16_normalize.sv
// Directed and random bench for fp16_normalize against a value-level model.
module tb_fp16_normalize;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [4:0]  in_exp = '0;
  logic [11:0] in_mant = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_result;
  logic        out_zero;
  logic        out_ovf;
  logic        out_uf;

  int checks = 0;
  int failures = 0;
  logic [15:0] got;

  always #5 clk = ~clk;

  fp16_normalize dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_ovf    (out_ovf),
    .out_uf     (out_uf)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Value-level model: find the leading one, shift as far as the
  // exponent floor allows, then pack.
  function automatic void model(input logic s, input logic [4:0] e_in,
                                input logic [11:0] m,
                                output logic [15:0] r, output logic z,
                                output logic o, output logic u,
                                output int lat);
    int e, p, need, sh;
    logic [11:0] mm;
    logic [11:0] half;
    e = (e_in == 0) ? 1 : int'(e_in);
    z = 0; o = 0; u = 0; lat = 2; p = 0;
    if (m == 0) begin
      r = {s, 15'b0};
      z = 1;
    end else if (m >= 12'd2048) begin
      e = e + 1;
      half = m >> 1;
      if (e == 31) begin
        r = {s, 5'h1F, 10'h0};
        o = 1;
      end else begin
        r = {s, 5'(e), half[9:0]};
      end
    end else if (m >= 12'd1024) begin
      r = {s, 5'(e), m[9:0]};
    end else begin
      for (int b = 0; b < 12; b++) if (m[b]) p = b;
      need = 10 - p;
      sh = (need < e - 1) ? need : e - 1;
      mm = m << sh;
      e = e - sh;
      lat = 2 + ((sh > 0) ? sh : 1);
      if (sh == need) begin
        r = {s, 5'(e), mm[9:0]};
      end else begin
`ifdef FP16_NORM_SUBNORM_EN
        r = {s, 5'h00, mm[9:0]};
`else
        r = {s, 15'b0};
        z = 1;
        u = 1;
`endif
      end
    end
  endfunction

  task automatic run_job(input logic s, input logic [4:0] e,
                         input logic [11:0] m, input int hold,
                         output logic [15:0] res);
    logic [15:0] r;
    logic z, o, u;
    int lat, k;
    model(s, e, m, r, z, o, u, lat);
    k = 0;
    while (!in_ready && k < 20) begin tick(); k++; end
    chk("idle_ready", in_ready, 1'b1);
    in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m;
    tick();
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 30) begin tick(); k++; end
    chk("latency", k + 1, lat);
    chk("result", out_result, r);
    chk("zero", out_zero, z);
    chk("ovf", out_ovf, o);
    chk("uf", out_uf, u);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_result", out_result, r);
      chk("hold_ready", in_ready, 1'b0);
    end
    res = out_result;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_valid", out_valid, 1'b0);
    chk("post_ready", in_ready, 1'b1);
  endtask

  initial begin
    logic [4:0] re;
    logic [11:0] rm;
    int k;
    tick();
    tick();
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_result", out_result, 16'h0);
    chk("rst_flags", {out_zero, out_ovf, out_uf}, 3'b000);
    rst = 1'b0;

    run_job(1'b0, 5'd15, 12'h400, 0, got);
    chk("t1_lit", got, 16'h3C00);
    run_job(1'b0, 5'd15, 12'h800, 0, got);
    chk("t2_lit", got, 16'h4000);
    run_job(1'b0, 5'd30, 12'hC00, 0, got);
    chk("t3_lit", got, 16'h7C00);
    run_job(1'b0, 5'd15, 12'h001, 0, got);
    chk("t4_lit", got, 16'h1400);
    run_job(1'b1, 5'd15, 12'h001, 0, got);
    chk("t4n_lit", got, 16'h9400);
    run_job(1'b0, 5'd3, 12'h010, 0, got);
`ifdef FP16_NORM_SUBNORM_EN
    chk("t5_lit", got, 16'h0040);
`else
    chk("t5_lit", got, 16'h0000);
`endif
    run_job(1'b1, 5'd7, 12'h000, 0, got);
    chk("t5z_lit", got, 16'h8000);
    run_job(1'b0, 5'd0, 12'h200, 0, got);
    run_job(1'b0, 5'd1, 12'h010, 0, got);
    run_job(1'b0, 5'd11, 12'h001, 0, got);
    run_job(1'b0, 5'd20, 12'h555, 5, got);
    chk("t6_lit", got, 16'h5155);

    // Reset in the middle of a shift sequence drops the job.
    k = 0;
    while (!in_ready && k < 20) begin tick(); k++; end
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 5'd15; in_mant = 12'h001;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_ready", in_ready, 1'b1);
    chk("mid_rst_result", out_result, 16'h0);
    rst = 1'b0;
    run_job(1'b1, 5'd15, 12'h400, 0, got);
    chk("after_rst_lit", got, 16'hBC00);

    for (int n = 0; n < 300; n++) begin
      re = 5'($urandom_range(0, 30));
      case ($urandom_range(0, 3))
        0: rm = 12'($urandom_range(0, 4095));
        1: rm = 12'($urandom_range(0, 15));
        2: rm = 12'($urandom_range(1024, 2047));
        default: rm = 12'($urandom_range(2048, 4095));
      endcase
      run_job(1'($urandom_range(0, 1)), re, rm,
              $urandom_range(0, 2), got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
